movegen_square_seq: RTL
=======================

Name: movegen_square_seq

Overview:
Parametrised square sequencer for the streamed position bus feeding move generation. Tags every valid position beat with its rank, file, linear index and first/last flags, for any FILES x RANKS board and either scan orientation. Tracks frame state so that short frames (early sop) and overrun beats (beats past the last square) are flagged, not silently mis-tagged. Sits directly on the in_pos bus; tag outputs are combinational so they align with the beat they describe and fan straight into downstream registers.

Parameters:
FILES, 8, squares per rank (>=2)
RANKS, 8, ranks per board (>=2)
FILE_W, $clog2(FILES), derived localparam: file field width
RANK_W, $clog2(RANKS), derived localparam: rank field width
IDX_W, $clog2(FILES*RANKS), derived localparam: linear index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_pos_valid  in  1  beat valid
in_pos_sop  in  1  first square of a position; qualified by in_pos_valid
in_order  in  1  orientation, sampled on the sop beat: 0 = FEN order (a8..h8, a7..h1), 1 = rotated 180 degrees (h1..a1, h2..a8)
out_valid  out  1  beat is inside a frame and tagged (combinational)
out_rank  out  RANK_W  rank of current beat (combinational)
out_file  out  FILE_W  file of current beat (combinational)
out_rankfile  out  RANK_W+FILE_W  {out_rank, out_file}
out_index  out  IDX_W  beat position within frame, 0..FILES*RANKS-1
out_first  out  1  out_valid and index 0
out_last  out  1  out_valid and index FILES*RANKS-1
out_frame_done  out  1  registered pulse, one cycle after the out_last beat
out_err_short  out  1  registered pulse, one cycle after a sop beat that arrives inside an unfinished frame
out_err_long  out  1  registered pulse, one cycle after a valid non-sop beat outside any frame

Behaviour:
- State: IDLE / IN_FRAME (2-state FSM) plus registered col (0..FILES-1), row (0..RANKS-1), index, and order_q.
- Reset (async assert, sync release): state IDLE; col, row, index = 0; order_q = 0; all registered pulses = 0. Combinational outputs follow from these registers and the inputs.
- Current-beat position: on a sop beat, col/row/index are forced to 0 and the mode is in_order (same cycle). Otherwise they come from the registers and order_q.
- Mapping with order 0: rank = RANKS-1-row, file = col. Mapping with order 1: rank = row, file = FILES-1-col.
- out_valid = in_pos_valid & (in_pos_sop | state==IN_FRAME). When out_valid = 0, the tag outputs are don't-care.
- Advance on each out_valid beat:
  - col wraps at FILES-1 and then increments row. No power-of-two assumption.
  - index increments.
  - On the last beat (index FILES*RANKS-1): state goes to IDLE, counters clear, out_frame_done pulses next cycle.
- Cycles with in_pos_valid = 0 hold all state. Gaps of any length are legal.
- sop in IDLE: starts a frame; order_q <= in_order; state IN_FRAME, unless FILES*RANKS = 1 (excluded by the parameter limits).
- sop in IN_FRAME: out_err_short pulses next cycle; the frame restarts at index 0 with the new order. That beat is tagged as index 0.
- sop coincident with what would have been the last beat: treated as a restart (err_short). It is not a completion.
- Valid non-sop beat in IDLE: out_valid = 0, counters unchanged, out_err_long pulses next cycle.
- in_pos_sop without in_pos_valid is ignored.
- Reset mid-frame: returns to IDLE immediately. The next beat needs sop, otherwise it raises err_long.

Decomposition:
- Shared package movegen_pkg:
  - typedef for the orientation enum (ORDER_FEN = 0, ORDER_ROT180 = 1)
  - FSM state enum
  - default board constants FILES_STD = 8, RANKS_STD = 8
- Natural sub-module: movegen_wrap_counter (parametrised MAX, async-reset counter with enable, synchronous clear and a wrap output). Instantiate it for col and row; index is a plain counter.

Test Plan:
- 8x8, order 0, sop followed by 64 contiguous beats -> out_rankfile: beat 0 = 0x38, beat 7 = 0x3F, beat 8 = 0x30, beat 63 = 0x07. out_first on beat 0 only, out_last on beat 63 only, out_frame_done one cycle later.
- 8x8, order 1, 64 beats with random valid gaps -> beat 0 = 0x07, beat 8 = 0x0F, beat 63 = 0x38. Indices are contiguous across gaps.
- Sop on beat 20 of a frame -> out_err_short pulses for 1 cycle, that beat has index 0 and rankfile 0x38. A following 64-beat frame completes cleanly.
- 65th beat after a completed frame (no sop) -> out_valid = 0, out_err_long pulses, the next sop beat is tagged index 0.
- FILES = 5, RANKS = 6, order 0 -> beat 4 = rank 5 file 4, beat 5 = rank 4 file 0, out_last on beat 29.
- rst_n asserted at beat 30 mid-frame -> outputs clear asynchronously. The post-reset beat without sop raises err_long; the post-reset beat with sop gets index 0.

Source files
------------

// File: rtl/movegen_pkg.sv
// Shared types and board constants for the move-generation square sequencer.
package movegen_pkg;

  typedef enum logic {
    ORDER_FEN    = 1'b0,
    ORDER_ROT180 = 1'b1
  } order_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } state_e;

  localparam int FILES_STD = 8;
  localparam int RANKS_STD = 8;

endpackage

// File: rtl/movegen_wrap_counter.sv
// Modulo-(MAX+1) counter with enable, same-beat restart and a wrap flag.
// The counter has no backpressure; clr makes the current beat read as zero, so clr with en leaves 1.
module movegen_wrap_counter #(
  parameter int MAX = 7,
  parameter int W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cur,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_q;

  assign cur  = clr ? '0 : count_q;
  assign wrap = en & (cur == MAX_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= wrap ? '0 : cur + 1'b1;
    end else if (clr) begin
      count_q <= '0;
    end
  end

endmodule

// File: rtl/movegen_square_seq.sv
// Tags each position beat with rank/file/index/first/last, combinationally aligned with the beat.
// Frame-done and error pulses are registered (1 cycle late); the input bus is never backpressured.
module movegen_square_seq
  import movegen_pkg::*;
#(
  parameter int FILES = FILES_STD,
  parameter int RANKS = RANKS_STD,
  localparam int FILE_W = $clog2(FILES),
  localparam int RANK_W = $clog2(RANKS),
  localparam int IDX_W  = $clog2(FILES * RANKS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_pos_valid,
  input  logic                     in_pos_sop,
  input  logic                     in_order,
  output logic                     out_valid,
  output logic [RANK_W-1:0]        out_rank,
  output logic [FILE_W-1:0]        out_file,
  output logic [RANK_W+FILE_W-1:0] out_rankfile,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_first,
  output logic                     out_last,
  output logic                     out_frame_done,
  output logic                     out_err_short,
  output logic                     out_err_long
);

  localparam int                 SQUARES  = FILES * RANKS;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(SQUARES - 1);
  localparam logic [RANK_W-1:0]  RANK_MAX = RANK_W'(RANKS - 1);
  localparam logic [FILE_W-1:0]  FILE_MAX = FILE_W'(FILES - 1);

  state_e              state_q;
  state_e              state_d;
  order_e              order_q;
  order_e              cur_order;
  logic                sop_beat;
  logic                adv;
  logic                is_last;
  logic [FILE_W-1:0]   col;
  logic [RANK_W-1:0]   row;
  logic                col_wrap;
  logic                row_wrap;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    cur_idx;
  logic                done_q;
  logic                short_q;
  logic                long_q;

  // A sop beat always re-bases the frame, even if it lands inside one.
  assign sop_beat  = in_pos_valid & in_pos_sop;
  assign adv       = in_pos_valid & (in_pos_sop | (state_q == ST_IN_FRAME));
  assign cur_idx   = sop_beat ? '0 : idx_q;
  assign is_last   = adv & (cur_idx == LAST_IDX);
  assign cur_order = sop_beat ? order_e'(in_order) : order_q;

  movegen_wrap_counter #(.MAX(FILES - 1), .W(FILE_W)) u_col (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .clr   (sop_beat),
    .cur   (col),
    .wrap  (col_wrap)
  );

  movegen_wrap_counter #(.MAX(RANKS - 1), .W(RANK_W)) u_row (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (col_wrap),
    .clr   (sop_beat),
    .cur   (row),
    .wrap  (row_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      order_q <= ORDER_FEN;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      if (adv) begin
        idx_q <= is_last ? '0 : cur_idx + 1'b1;
      end
      if (sop_beat) begin
        order_q <= order_e'(in_order);
      end
      done_q  <= is_last;
      short_q <= sop_beat & (state_q == ST_IN_FRAME);
      long_q  <= in_pos_valid & ~in_pos_sop & (state_q == ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Row wrap coincides with the final square; both counters return to zero on it.
  always_comb begin
    state_d = state_q;
    if (adv) begin
      state_d = row_wrap ? ST_IDLE : ST_IN_FRAME;
    end
  end

  always_comb begin
    out_valid    = adv;
    out_rank     = (cur_order == ORDER_FEN) ? (RANK_MAX - row) : row;
    out_file     = (cur_order == ORDER_FEN) ? col : (FILE_MAX - col);
    out_rankfile = {out_rank, out_file};
    out_index    = cur_idx;
    out_first    = adv & (cur_idx == '0);
    out_last     = is_last;
  end

  assign out_frame_done = done_q;
  assign out_err_short  = short_q;
  assign out_err_long   = long_q;

endmodule
